// File: rtl/rr_burst_sched.sv
// Round-robin grant of one shared burst sequencer among NREQ requesters; drives go/last_beat per beat.
// Latency: grant registered one cycle after first; done one cycle after the final beat.
// Backpressure: ready=0 freezes the beat count and state; requests are ignored until the burst ends.
module rr_burst_sched #(
    parameter int NREQ = 4,
    parameter int LENW = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    input  logic                 ready,
    output logic                 first,
    output logic                 go,
    output logic                 last_beat,
    output logic [NREQ-1:0]      gnt,
    output logic [IDW-1:0]       gnt_id,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [LENW-1:0] rem, rem_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [IDW-1:0]  gnt_id_nxt;
    logic            done_nxt;

    logic            found;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  cand;
    logic [LENW-1:0] win_len;

    // Scan starts just past the last winner, so that winner ends up lowest priority.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    assign win_len = len[int'(win_id)*LENW +: LENW];

    always_comb begin
        state_nxt  = state;
        rem_nxt    = rem;
        ptr_nxt    = ptr;
        gnt_nxt    = gnt;
        gnt_id_nxt = gnt_id;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (found) begin
                    gnt_nxt    = NREQ'(1) << win_id;
                    gnt_id_nxt = win_id;
                    rem_nxt    = win_len;
                    state_nxt  = (win_len == '0) ? LAST : RUN;
                end
            end
            RUN: begin
                if (ready) begin
                    rem_nxt = rem - LENW'(1);
                    if (rem == LENW'(1)) begin
                        state_nxt = LAST;
                    end
                end
            end
            LAST: begin
                if (ready) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = gnt_id;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                rem_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rem    <= '0;
            ptr    <= IDW'(NREQ - 1);
            gnt    <= '0;
            gnt_id <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rem    <= rem_nxt;
            ptr    <= ptr_nxt;
            gnt    <= gnt_nxt;
            gnt_id <= gnt_id_nxt;
            done   <= done_nxt;
        end
    end

    // first is gated by rst so no grant is advertised while the block is held in reset.
    assign first     = !rst && (state == IDLE) && found;
    assign go        = (state == RUN) || (state == LAST);
    assign last_beat = (state == LAST);

endmodule

// File: tb/tb_rr_burst_sched.sv
// Directed bench for rr_burst_sched: reset, single burst, stalls, rotation, fairness skip, reset mid-burst.
module tb_rr_burst_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic        ready;
    logic        first;
    logic        go;
    logic        last_beat;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        done;

    int total;
    int passed;
    int failed;

    rr_burst_sched #(.NREQ(4), .LENW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .len       (len),
        .ready     (ready),
        .first     (first),
        .go        (go),
        .last_beat (last_beat),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_ids [5];
        total  = 0;
        passed = 0;
        failed = 0;
        exp_ids = '{0, 1, 2, 3, 0};

        // Reset held with all requests and ready high
        rst   = 1'b1;
        req   = 4'b1111;
        len   = 16'h0000;
        ready = 1'b1;
        #2;
        for (int c = 0; c < 3; c++) begin
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_go", 32'(go), 32'h0);
            chk("rst_done", 32'(done), 32'h0);
            chk("rst_first", 32'(first), 32'h0);
            chk("rst_last", 32'(last_beat), 32'h0);
            tick();
        end
        rst = 1'b0;
        #1;

        // Rotation with 1-beat bursts: grant every 2 cycles, done coincides with first
        for (int k = 0; k < 5; k++) begin
            chk("rot_first", 32'(first), 32'h1);
            if (k > 0) chk("rot_done", 32'(done), 32'h1);
            tick();
            chk("rot_gnt_id", 32'(gnt_id), 32'(exp_ids[k]));
            chk("rot_gnt", 32'(gnt), 32'h1 << exp_ids[k]);
            chk("rot_last", 32'(last_beat), 32'h1);
            chk("rot_done_lo", 32'(done), 32'h0);
            if (k == 4) req = 4'b0000;
            tick();
        end
        chk("rot_end_done", 32'(done), 32'h1);
        chk("rot_end_first", 32'(first), 32'h0);
        chk("rot_end_gnt", 32'(gnt), 32'h0);
        chk("rot_hold_id", 32'(gnt_id), 32'h0);
        tick();
        chk("idle_done", 32'(done), 32'h0);
        chk("idle_go", 32'(go), 32'h0);

        // Fairness skip: requester 1 completes, then 0 wins over 1
        req = 4'b0010;
        #1;
        chk("fair_first1", 32'(first), 32'h1);
        tick();
        chk("fair_id1", 32'(gnt_id), 32'h1);
        req = 4'b0011;
        tick();
        chk("fair_done1", 32'(done), 32'h1);
        tick();
        chk("fair_skip_id", 32'(gnt_id), 32'h0);
        chk("fair_skip_gnt", 32'(gnt), 32'h1);
        req = 4'b0010;
        tick();
        chk("fair_first2", 32'(first), 32'h1);
        tick();
        chk("fair_id2", 32'(gnt_id), 32'h1);
        req = 4'b0000;
        tick();
        tick();

        // Single 3-beat burst for requester 0
        req = 4'b0001;
        len = 16'h0002;
        #1;
        chk("sb_first", 32'(first), 32'h1);
        tick();
        req = 4'b0000;
        for (int c = 1; c <= 3; c++) begin
            chk("sb_go", 32'(go), 32'h1);
            chk("sb_gnt", 32'(gnt), 32'h1);
            chk("sb_last", 32'(last_beat), (c == 3) ? 32'h1 : 32'h0);
            chk("sb_done_lo", 32'(done), 32'h0);
            tick();
        end
        chk("sb_done", 32'(done), 32'h1);
        chk("sb_go_off", 32'(go), 32'h0);
        chk("sb_gnt_off", 32'(gnt), 32'h0);
        tick();
        chk("sb_done_once", 32'(done), 32'h0);

        // Same burst with ready stalls in T+2 and the first LAST cycle
        req = 4'b0001;
        #1;
        chk("st_first", 32'(first), 32'h1);
        tick();
        req = 4'b0000;
        chk("st_run1", 32'(go), 32'h1);
        tick();
        ready = 1'b0;
        chk("st_run2_last", 32'(last_beat), 32'h0);
        tick();
        ready = 1'b1;
        chk("st_run3_last", 32'(last_beat), 32'h0);
        chk("st_run3_go", 32'(go), 32'h1);
        tick();
        ready = 1'b0;
        chk("st_last1", 32'(last_beat), 32'h1);
        tick();
        ready = 1'b1;
        chk("st_last2", 32'(last_beat), 32'h1);
        chk("st_done_lo", 32'(done), 32'h0);
        tick();
        chk("st_done", 32'(done), 32'h1);
        chk("st_last_off", 32'(last_beat), 32'h0);
        chk("st_hold_id", 32'(gnt_id), 32'h0);
        tick();

        // Reset in the middle of a 4-beat burst for requester 2
        req = 4'b0100;
        len = 16'h0300;
        #1;
        chk("rm_first", 32'(first), 32'h1);
        tick();
        chk("rm_gnt", 32'(gnt), 32'h4);
        req = 4'b0101;
        tick();
        chk("rm_run_go", 32'(go), 32'h1);
        rst = 1'b1;
        #1;
        chk("rm_gnt_clr", 32'(gnt), 32'h0);
        chk("rm_go_clr", 32'(go), 32'h0);
        chk("rm_last_clr", 32'(last_beat), 32'h0);
        chk("rm_done_clr", 32'(done), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rm_no_done", 32'(done), 32'h0);
        chk("rm_first2", 32'(first), 32'h1);
        tick();
        chk("rm_gnt0", 32'(gnt), 32'h1);
        chk("rm_id0", 32'(gnt_id), 32'h0);
        chk("rm_no_done2", 32'(done), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_burst_sched.md
Name: rr_burst_sched

Overview:
- Round-robin scheduler that shares one burst-oriented sequencer between NREQ requesters.
- Each requester asks for a burst of len+1 beats. The block picks a winner, drives the shared sequencer's go/last handshake beat by beat, and signals completion.
- Sits in front of the IDLE/RUN/LAST-style sequencer FSMs. It replaces per-client direct drive of the sequencer's go input.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- LENW, 4, width of each burst-length field. Burst length in beats = len+1, range 1..2^LENW.
- IDW, $clog2(NREQ), localparam; width of the granted index.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- len  input  NREQ*LENW  per-requester burst length minus 1. Requester i uses bits [i*LENW +: LENW].
- ready  input  1  the shared sequencer accepts a beat this cycle.
- first  output  1  combinational; pulses on the arbitration transition.
- go  output  1  decoded from the state register; high while a burst is active.
- last_beat  output  1  decoded from the state register; high while the final beat is pending.
- gnt  output  NREQ  registered one-hot grant.
- gnt_id  output  IDW  registered index of the granted requester.
- done  output  1  registered one-cycle pulse after the burst completes.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (rst).
- While rst is high, all of the following hold:
  - state = IDLE
  - gnt = 0, gnt_id = 0, done = 0
  - rem = 0
  - ptr = NREQ-1, so requester 0 has highest priority after reset.
- Since go and last_beat are state decodes, both are 0 while rst is high.
- States are IDLE, RUN and LAST. Any unreachable encoding returns to IDLE.
- IDLE:
  - If |req, the winner is the first set req bit scanning ptr+1, ptr+2, … modulo NREQ.
  - In that same cycle, first = 1 combinationally.
  - On the next edge:
    - gnt gets the winner's one-hot bit and gnt_id gets the winner's index.
    - rem gets that requester's len.
    - The next state is LAST if len == 0, otherwise RUN.
  - With no request, the block stays in IDLE and first = 0.
- RUN:
  - go = 1, last_beat = 0.
  - A beat is a cycle with ready = 1. Each beat decrements rem.
  - On a beat with rem == 1, the next state is LAST (rem becomes 0).
  - ready = 0 holds the state and rem.
- LAST:
  - go = 1, last_beat = 1.
  - On ready = 1, the block moves to IDLE, clears gnt, sets ptr = gnt_id, and sets done = 1 for exactly the following cycle.
  - ready = 0 holds the block in LAST indefinitely.
- gnt_id holds its value after completion, until the next grant.
- done is a registered pulse, high only in the first IDLE cycle after LAST. It is 0 in every other cycle.
- Request changes mid-burst:
  - req and len changes during RUN/LAST are ignored; the burst always completes.
  - Deasserting the granted req mid-burst does not abort the burst.
- Minimum spacing between grants:
  - The earliest next first pulse falls in the same cycle as done, i.e. the first IDLE cycle.
  - A 1-beat burst with ready held high therefore gives one grant every 2 cycles.
- The last-granted requester gets the lowest priority in the next arbitration, even if its req is still high.
- gnt is 0 in IDLE and one-hot in RUN/LAST.
- go is 1 exactly when state is RUN or LAST. first, go and last_beat have no combinational path from ready.
- Reset mid-burst: rst clears all state asynchronously, even within a cycle. No done is generated for the aborted burst. The next grant starts from requester 0.

Test Plan:
1. Reset:
   - Stimulus: assert rst with req = 4'b1111 and ready = 1.
   - Required: gnt = 0, go = 0, done = 0 and first = 0 throughout. After release, first = 1 in the first cycle and gnt = 4'b0001 one cycle later.
2. Single burst:
   - Stimulus: req = 4'b0001, len0 = 2, ready = 1; first is high at cycle T.
   - Required: go is high in T+1..T+3, gnt = 4'b0001 in T+1..T+3, last_beat only in T+3, done only in T+4.
3. Ready stalls:
   - Stimulus: same as scenario 2, with ready = 0 in T+2 and in the first LAST cycle.
   - Required: exactly 3 accepted beats, done at T+6, last_beat held for 2 cycles.
4. Rotation:
   - Stimulus: req = 4'b1111 held, all len = 0, ready = 1.
   - Required: gnt_id sequence 0, 1, 2, 3, 0, with one grant every 2 cycles. done coincides with the next first pulse.
5. Fairness skip:
   - Stimulus: after requester 1 completes, req = 4'b0011.
   - Required: next grant = 0. Then with req = 4'b0010 only, the next grant = 1.
6. Reset mid-burst:
   - Stimulus: assert rst while in RUN with gnt = 4'b0100.
   - Required: gnt, go and last_beat clear immediately, with no done pulse. After release with req = 4'b0101, the grant goes to 0.
